// File: rtl/write_back_pkg.sv
// Shared definitions for the write-back stage: datapath widths, control-word
// bit positions and load-size encodings.
package write_back_pkg;

  localparam int unsigned LEN     = 32;
  localparam int unsigned NB_CTRL = 8;

  // Control word bit positions
  localparam int unsigned CTRL_REGWRITE = 7;
  localparam int unsigned CTRL_MEMTOREG = 6;
  localparam int unsigned CTRL_UNSIGNED = 5;
  localparam int unsigned CTRL_SIZE_HI  = 4;
  localparam int unsigned CTRL_SIZE_LO  = 3;

  localparam int unsigned NB_SIZE = 2;

  typedef logic [NB_SIZE-1:0] load_size_t;

  // LoadSize encodings; 2'b10 is also treated as a word
  localparam load_size_t SIZE_BYTE = 2'b00;
  localparam load_size_t SIZE_HALF = 2'b01;
  localparam load_size_t SIZE_WORD = 2'b11;

endpackage

// File: rtl/write_back_if.sv
// Bus between the memory/ALU stage and the write-back stage, including the
// register-file write port it drives.
interface write_back_if #(
  parameter int unsigned len               = 32,
  parameter int unsigned NB_SENIAL_CONTROL = 8
);

  logic [len-1:0]               i_read_data;
  logic [len-1:0]               i_result_alu;
  logic [NB_SENIAL_CONTROL-1:0] i_senial_control;
  logic [len-1:0]               o_write_data;
  logic                         o_reg_write;

  modport master (
    output i_read_data,
    output i_result_alu,
    output i_senial_control,
    input  o_write_data,
    input  o_reg_write
  );

  modport slave (
    input  i_read_data,
    input  i_result_alu,
    input  i_senial_control,
    output o_write_data,
    output o_reg_write
  );

endinterface

// File: rtl/write_back_load_extend.sv
// Load-width selection with sign or zero extension of the memory read word.
module write_back_load_extend
  import write_back_pkg::*;
#(
  parameter int unsigned len = LEN
) (
  input  logic [len-1:0] data,
  input  load_size_t     size,
  input  logic           is_unsigned,
  output logic [len-1:0] ext
);

  logic fill;

  // Fill bit is the MSB of the selected field for signed loads, else zero
  always_comb begin
    fill = 1'b0;
    ext  = data;
    case (size)
      SIZE_BYTE: begin
        fill = ~is_unsigned & data[7];
        ext  = {{(len-8){fill}}, data[7:0]};
      end
      SIZE_HALF: begin
        fill = ~is_unsigned & data[15];
        ext  = {{(len-16){fill}}, data[15:0]};
      end
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/write_back.sv
// MIPS write-back stage: selects memory or ALU data and registers the
// register-file write data and write enable.
module write_back
  import write_back_pkg::*;
#(
  parameter int unsigned len               = LEN,
  parameter int unsigned NB_SENIAL_CONTROL = NB_CTRL
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  write_back_if.slave wb
);

  logic [len-1:0] ext_data;
  logic [len-1:0] next_data;
  logic           ctrl_unused;

  write_back_load_extend #(
    .len (len)
  ) u_load_extend (
    .data        (wb.i_read_data),
    .size        (wb.i_senial_control[CTRL_SIZE_HI:CTRL_SIZE_LO]),
    .is_unsigned (wb.i_senial_control[CTRL_UNSIGNED]),
    .ext         (ext_data)
  );

  // Low control bits belong to other pipeline stages
  assign ctrl_unused = ^wb.i_senial_control[CTRL_SIZE_LO-1:0];

  assign next_data = wb.i_senial_control[CTRL_MEMTOREG] ? ext_data : wb.i_result_alu;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wb.o_write_data <= '0;
      wb.o_reg_write  <= 1'b0;
    end else begin
      wb.o_write_data <= next_data;
      wb.o_reg_write  <= wb.i_senial_control[CTRL_REGWRITE];
    end
  end

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: directed vectors plus randomized traffic
// against a behavioural model of the load/mux/register behaviour.
`timescale 1ns/1ps
module tb_write_back;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   cmp_en = 1'b0;

  logic [31:0] m_data = 32'h0;
  logic        m_we   = 1'b0;

  write_back_if #(.len(32), .NB_SENIAL_CONTROL(8)) bus ();

  write_back #(.len(32), .NB_SENIAL_CONTROL(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .wb      (bus.slave)
  );

  always #5 clk = ~clk;

  // Expected write data from the load rules, using plain arithmetic
  function automatic logic [31:0] model_data(input logic [31:0] rd,
                                             input logic [31:0] alu,
                                             input logic [7:0]  ctrl);
    logic [31:0] w;
    if (!ctrl[6]) return alu;
    case (ctrl[4:3])
      2'b00: begin
        w = rd % 32'd256;
        if (!ctrl[5] && w >= 32'd128) w = w + 32'hFFFF_FF00;
      end
      2'b01: begin
        w = rd % 32'd65536;
        if (!ctrl[5] && w >= 32'd32768) w = w + 32'hFFFF_0000;
      end
      default: w = rd;
    endcase
    return w;
  endfunction

  // Reference output register
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data = 32'h0;
      m_we   = 1'b0;
    end else begin
      m_data = model_data(bus.i_read_data, bus.i_result_alu, bus.i_senial_control);
      m_we   = bus.i_senial_control[7];
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check32("model_data", bus.o_write_data, m_data);
      check1("model_we", bus.o_reg_write, m_we);
    end
  end

  task automatic drive(input logic [31:0] rd, input logic [31:0] alu, input logic [7:0] ctrl);
    bus.i_read_data      = rd;
    bus.i_result_alu     = alu;
    bus.i_senial_control = ctrl;
  endtask

  // Drive a vector, let it be captured, then check literal expectations
  task automatic apply(input string name, input logic [31:0] rd, input logic [31:0] alu,
                       input logic [7:0] ctrl, input logic [31:0] exp_d, input logic exp_we);
    drive(rd, alu, ctrl);
    @(posedge clk);
    #1;
    check32({name, "_data"}, bus.o_write_data, exp_d);
    check1({name, "_we"}, bus.o_reg_write, exp_we);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(32'hDEAD_BEEF, 32'h1234_5678, 8'hFF);
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;

    // Reset held with toggling inputs
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      drive($urandom, $urandom, 8'($urandom));
      check32("rst_hold_data", bus.o_write_data, 32'h0);
      check1("rst_hold_we", bus.o_reg_write, 1'b0);
    end

    // Release; first capture on the following edge
    rst_n = 1'b1;
    apply("load_word",  32'h0000_0003, 32'h0000_0010, 8'b1101_1000, 32'h0000_0003, 1'b1);
    apply("rtype",      32'h0000_0002, 32'h0000_0110, 8'b1000_0001, 32'h0000_0110, 1'b1);
    apply("lb_signed",  32'h1234_80F3, 32'h0,         8'b1100_0000, 32'hFFFF_FFF3, 1'b1);
    apply("lb_unsign",  32'h1234_80F3, 32'h0,         8'b1110_0000, 32'h0000_00F3, 1'b1);
    apply("lh_signed",  32'h1234_80F3, 32'h0,         8'b1100_1000, 32'hFFFF_80F3, 1'b1);
    apply("lh_unsign",  32'h1234_80F3, 32'h0,         8'b1110_1000, 32'h0000_80F3, 1'b1);
    apply("size10_word",32'h8765_4321, 32'h0,         8'b1111_0000, 32'h8765_4321, 1'b1);
    apply("lb_pos",     32'hFFFF_FF71, 32'h0,         8'b1100_0000, 32'h0000_0071, 1'b1);
    apply("alu_ignore", 32'hFFFF_FFFF, 32'hCAFE_0001, 8'b1010_1000, 32'hCAFE_0001, 1'b1);
    apply("no_regwr",   32'h1234_80F3, 32'h0,         8'b0100_0000, 32'hFFFF_FFF3, 1'b0);

    // Async reset mid-cycle after a load
    apply("pre_rst",    32'hA5A5_5A5A, 32'h0,         8'b1101_1000, 32'hA5A5_5A5A, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check32("async_rst_data", bus.o_write_data, 32'h0);
    check1("async_rst_we", bus.o_reg_write, 1'b0);
    @(posedge clk);
    #1;
    check32("rst_edge_data", bus.o_write_data, 32'h0);
    rst_n = 1'b1;
    apply("post_rst",   32'h0000_0000, 32'h0000_0042, 8'b1000_0000, 32'h0000_0042, 1'b1);

    // Randomized traffic with occasional reset pulses
    for (int i = 0; i < 400; i++) begin
      logic [31:0] rd;
      rd = $urandom;
      if ($urandom_range(3) == 0) rd[7] = 1'b1;
      if ($urandom_range(3) == 0) rd[15] = 1'b1;
      drive(rd, $urandom, 8'($urandom));
      if ($urandom_range(49) == 0) begin
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
